downcounter: RTL and testbench

DOWNCOUNTER -- requirements
Module: downcounter

---
 rtl/downcounter_pkg.sv | 28 ++
 rtl/tflipflop_ar.sv | 17 +
 rtl/downcounter.sv | 54 +++++
 tb/tb_downcounter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/downcounter_pkg.sv
// Shared counter constants and single-bit gate helpers for the ripple-borrow counters.
// Every gate in the borrow chain goes through these helpers, so the counter needs no arithmetic operators.
package downcounter_pkg;

  localparam int CNT_DEFAULT_N = 4;
  localparam int CNT_MAX_N     = 32;

  localparam logic [CNT_MAX_N-1:0] CNT_ZERO     = '0;
  localparam logic [CNT_MAX_N-1:0] CNT_ALL_ONES = '1;

  function automatic logic g_inv(input logic a);
    return ~a;
  endfunction

  function automatic logic g_and2(input logic a, input logic b);
    return a & b;
  endfunction

  function automatic logic g_xor2(input logic a, input logic b);
    return a ^ b;
  endfunction

  // sel=1 selects b, sel=0 selects a
  function automatic logic g_mux2(input logic sel, input logic a, input logic b);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/tflipflop_ar.sv
// Toggle flip-flop with asynchronous active-high reset; one instance holds each counter bit.
module tflipflop_ar (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/downcounter.sv
// N-bit cascadable down-counter built from toggle flip-flops and a per-bit borrow chain.
// Supports a synchronous parallel load and an optional stop-at-zero (oneshot) mode.
module downcounter
  import downcounter_pkg::*;
#(
  parameter int N = CNT_DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         oneshot,
  output logic [N-1:0] q,
  output logic         zero,
  output logic         borrow
);

  logic [N:0]   b;
  logic [N-1:0] t;
  logic         is_zero;
  logic         hold;

  assign is_zero = (q == CNT_ZERO[N-1:0]);

  // At zero the whole borrow chain is high, so every bit would toggle to all-ones;
  // oneshot mode suppresses that toggle so the count parks at zero.
  assign hold = g_and2(oneshot, is_zero);

  assign b[0] = en;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_bit
      assign b[i+1] = g_and2(b[i], g_inv(q[i]));

      // A load toggles exactly the bits that differ from d, which makes the flop land on d.
      assign t[i] = g_mux2(load,
                           g_and2(b[i], g_inv(hold)),
                           g_xor2(q[i], d[i]));

      tflipflop_ar u_tff (
        .clk   (clk),
        .reset (reset),
        .t     (t[i]),
        .q     (q[i])
      );
    end
  endgenerate

  assign zero   = is_zero;
  assign borrow = g_and2(b[N], g_and2(g_inv(load), g_inv(oneshot)));

endmodule

// File: tb/tb_downcounter.sv
// Directed bench for downcounter: single-stage vector table, hand-written reset/hold
// sequences, and a two-stage cascade.
module tb_downcounter;
  import downcounter_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] d;
  logic       oneshot;
  logic [3:0] q;
  logic       zero;
  logic       borrow;

  logic       c_en;
  logic       c_load;
  logic [7:0] c_d;
  logic [3:0] lo_q;
  logic [3:0] hi_q;
  logic       lo_zero;
  logic       hi_zero;
  logic       lo_borrow;
  logic       hi_borrow;
  logic       c_oneshot;

  int errors;
  int checks;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       load;
    logic       en;
    logic       oneshot;
    logic [3:0] d;
    logic       exp_borrow;
    logic [3:0] exp_q;
    logic       exp_zero;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  downcounter #(.N(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .d       (d),
    .oneshot (oneshot),
    .q       (q),
    .zero    (zero),
    .borrow  (borrow)
  );

  downcounter #(.N(4)) u_lo (
    .clk     (clk),
    .reset   (reset),
    .en      (c_en),
    .load    (c_load),
    .d       (c_d[3:0]),
    .oneshot (c_oneshot),
    .q       (lo_q),
    .zero    (lo_zero),
    .borrow  (lo_borrow)
  );

  downcounter #(.N(4)) u_hi (
    .clk     (clk),
    .reset   (reset),
    .en      (lo_borrow),
    .load    (c_load),
    .d       (c_d[7:4]),
    .oneshot (c_oneshot),
    .q       (hi_q),
    .zero    (hi_zero),
    .borrow  (hi_borrow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, check borrow before the rising edge and q/zero after it.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    load    = v.load;
    en      = v.en;
    oneshot = v.oneshot;
    d       = v.d;
    #1;
    check($sformatf("vec%0d_borrow", idx), 32'(borrow), 32'(v.exp_borrow));
    @(posedge clk);
    #1;
    check($sformatf("vec%0d_q", idx), 32'(q), 32'(v.exp_q));
    check($sformatf("vec%0d_zero", idx), 32'(zero), 32'(v.exp_zero));
  endtask

  initial begin
    logic [3:0] ones4;
    logic [7:0] prev;
    logic [7:0] e;
    logic       exp_b;

    errors    = 0;
    checks    = 0;
    ones4     = CNT_ALL_ONES[3:0];
    reset     = 1'b1;
    en        = 1'b0;
    load      = 1'b0;
    d         = 4'h0;
    oneshot   = 1'b0;
    c_en      = 1'b0;
    c_load    = 1'b0;
    c_d       = 8'h00;
    c_oneshot = 1'b0;

    //                load  en    os    d     borrow q      zero
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 4'h3,  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h2,  1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h1,  1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0,  1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, ones4, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 4'h2,  1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h1,  1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0,  1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0,  1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0,  1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 4'h9, 1'b0, 4'h9,  1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 4'h5,  1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 4'hA, 1'b0, 4'hA,  1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h9,  1'b0};

    // reset state, with clock edges and load active during reset
    @(negedge clk);
    load = 1'b1;
    d    = 4'h6;
    @(negedge clk);
    check("reset_q", 32'(q), 32'h0);
    check("reset_zero", 32'(zero), 32'h1);
    check("reset_borrow", 32'(borrow), 32'h0);
    load  = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(i, vecs[i]);
    end

    // hold with en=0
    @(negedge clk);
    load = 1'b1;
    en   = 1'b0;
    d    = 4'h7;
    @(posedge clk);
    #1;
    check("hold_load_q", 32'(q), 32'h7);
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_q", i), 32'(q), 32'h7);
      check($sformatf("hold%0d_borrow", i), 32'(borrow), 32'h0);
    end

    // asynchronous reset mid-count
    @(negedge clk);
    load = 1'b1;
    d    = 4'h6;
    @(posedge clk);
    #1;
    check("arst_load_q", 32'(q), 32'h6);
    @(negedge clk);
    load = 1'b0;
    en   = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("arst_q_immediate", 32'(q), 32'h0);
    check("arst_zero", 32'(zero), 32'h1);
    check("arst_borrow", 32'(borrow), 32'h1);
    load = 1'b1;
    d    = 4'h5;
    @(posedge clk);
    #1;
    check("arst_edge_q", 32'(q), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    en    = 1'b1;
    @(posedge clk);
    #1;
    check("arst_resume_q", 32'(q), 32'(ones4));
    @(negedge clk);
    en = 1'b0;

    // two-stage cascade behaves as one 8-bit counter
    c_load = 1'b1;
    c_d    = 8'h01;
    @(posedge clk);
    #1;
    check("casc_load", 32'({hi_q, lo_q}), 32'h01);
    @(negedge clk);
    c_load = 1'b0;
    c_en   = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFE);
    for (int i = 0; i < 3; i++) begin
      prev  = {hi_q, lo_q};
      exp_b = (i == 1);
      check($sformatf("casc%0d_borrow", i), 32'(lo_borrow), 32'(exp_b));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("casc%0d_q", i), 32'({hi_q, lo_q}), 32'(e));
      check($sformatf("casc%0d_hi_change", i), 32'(hi_q != prev[7:4]), 32'(i == 1));
      @(negedge clk);
    end
    c_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
